// File: rtl/exe_stage_mdu_if.sv
// ID/EXE -> EXE -> EXE/MEM bundle for the execute stage.
// master drives the pipe side, slave is the execute stage itself.
interface exe_stage_mdu_if #(
  parameter int WORD_LEN          = 32,
  parameter int EXE_CMD_LEN       = 4,
  parameter int REG_FILE_ADDR_LEN = 5
);
  logic [EXE_CMD_LEN-1:0]       EXE_CMD;
  logic [WORD_LEN-1:0]          val1, val2, ST_value, PC;
  logic                         MEM_R_EN, MEM_W_EN, WB_EN, brTaken;
  logic [REG_FILE_ADDR_LEN-1:0] dest;
  logic [1:0]                   fwd_sel1, fwd_sel2, fwd_sel_st;
  logic [WORD_LEN-1:0]          mem_fwd_val, wb_fwd_val;

  logic [WORD_LEN-1:0]          alu_result, st_value_out, br_addr;
  logic                         MEM_R_EN_out, MEM_W_EN_out, WB_EN_out, br_taken_out;
  logic [REG_FILE_ADDR_LEN-1:0] dest_out;
  logic                         stall;

  modport master (
    output EXE_CMD, val1, val2, ST_value, PC, MEM_R_EN, MEM_W_EN, WB_EN, brTaken,
           dest, fwd_sel1, fwd_sel2, fwd_sel_st, mem_fwd_val, wb_fwd_val,
    input  alu_result, st_value_out, br_addr, MEM_R_EN_out, MEM_W_EN_out,
           WB_EN_out, br_taken_out, dest_out, stall
  );

  modport slave (
    input  EXE_CMD, val1, val2, ST_value, PC, MEM_R_EN, MEM_W_EN, WB_EN, brTaken,
           dest, fwd_sel1, fwd_sel2, fwd_sel_st, mem_fwd_val, wb_fwd_val,
    output alu_result, st_value_out, br_addr, MEM_R_EN_out, MEM_W_EN_out,
           WB_EN_out, br_taken_out, dest_out, stall
  );
endinterface

// File: rtl/exe_stage_mdu.sv
// Execute stage: operand forwarding, single-cycle ALU, and an iterative
// shift-add multiplier / restoring divider that stalls the front end.
module exe_stage_mdu #(
  parameter int WORD_LEN          = 32,
  parameter int EXE_CMD_LEN       = 4,
  parameter int REG_FILE_ADDR_LEN = 5
) (
  input  logic            clk,
  input  logic            rst,
  exe_stage_mdu_if.slave  bus
);
  localparam int SHW  = $clog2(WORD_LEN);
  localparam int CNTW = $clog2(WORD_LEN + 1);

  localparam logic [EXE_CMD_LEN-1:0] CMD_ADD  = EXE_CMD_LEN'(1);
  localparam logic [EXE_CMD_LEN-1:0] CMD_SUB  = EXE_CMD_LEN'(2);
  localparam logic [EXE_CMD_LEN-1:0] CMD_AND  = EXE_CMD_LEN'(3);
  localparam logic [EXE_CMD_LEN-1:0] CMD_OR   = EXE_CMD_LEN'(4);
  localparam logic [EXE_CMD_LEN-1:0] CMD_XOR  = EXE_CMD_LEN'(5);
  localparam logic [EXE_CMD_LEN-1:0] CMD_SLL  = EXE_CMD_LEN'(6);
  localparam logic [EXE_CMD_LEN-1:0] CMD_SRL  = EXE_CMD_LEN'(7);
  localparam logic [EXE_CMD_LEN-1:0] CMD_SLT  = EXE_CMD_LEN'(8);
  localparam logic [EXE_CMD_LEN-1:0] CMD_MUL  = EXE_CMD_LEN'(9);
  localparam logic [EXE_CMD_LEN-1:0] CMD_DIVU = EXE_CMD_LEN'(10);
  localparam logic [EXE_CMD_LEN-1:0] CMD_REMU = EXE_CMD_LEN'(11);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic [EXE_CMD_LEN-1:0] op_q, op_d;
  // MUL: a = multiplicand (shifts left), b = multiplier (shifts right), acc = product.
  // DIV: a = dividend shifting into quotient, b = divisor, acc = partial remainder.
  logic [WORD_LEN-1:0]    a_q, a_d, b_q, b_d, acc_q, acc_d;

  logic [WORD_LEN-1:0]    op_a, op_b, op_s, alu_comb, mdu_res;
  logic [WORD_LEN:0]      div_r, div_diff;
  logic                   is_mdu, stall_int, kill;

  function automatic logic [WORD_LEN-1:0] fwd_mux(input logic [1:0] sel,
                                                  input logic [WORD_LEN-1:0] pipe,
                                                  input logic [WORD_LEN-1:0] memv,
                                                  input logic [WORD_LEN-1:0] wbv);
    case (sel)
      2'd1:    return memv;
      2'd2:    return wbv;
      default: return pipe;
    endcase
  endfunction

  always_comb begin
    op_a = fwd_mux(bus.fwd_sel1,   bus.val1,     bus.mem_fwd_val, bus.wb_fwd_val);
    op_b = fwd_mux(bus.fwd_sel2,   bus.val2,     bus.mem_fwd_val, bus.wb_fwd_val);
    op_s = fwd_mux(bus.fwd_sel_st, bus.ST_value, bus.mem_fwd_val, bus.wb_fwd_val);

    alu_comb = '0;
    case (bus.EXE_CMD)
      CMD_ADD: alu_comb = op_a + op_b;
      CMD_SUB: alu_comb = op_a - op_b;
      CMD_AND: alu_comb = op_a & op_b;
      CMD_OR:  alu_comb = op_a | op_b;
      CMD_XOR: alu_comb = op_a ^ op_b;
      CMD_SLL: alu_comb = op_a << op_b[SHW-1:0];
      CMD_SRL: alu_comb = op_a >> op_b[SHW-1:0];
      CMD_SLT: alu_comb = {{(WORD_LEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      default: alu_comb = '0;
    endcase

    is_mdu = (bus.EXE_CMD == CMD_MUL) || (bus.EXE_CMD == CMD_DIVU) ||
             (bus.EXE_CMD == CMD_REMU);
  end

  // Restoring divide step; a zero divisor naturally yields all-ones / dividend.
  always_comb begin
    div_r    = {acc_q, a_q[WORD_LEN-1]};
    div_diff = div_r - {1'b0, b_q};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    stall_int = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_mdu) begin
          stall_int = 1'b1;
          state_d   = S_BUSY;
          cnt_d     = CNTW'(WORD_LEN);
          op_d      = bus.EXE_CMD;
          a_d       = op_a;
          b_d       = op_b;
          acc_d     = '0;
        end
      end
      S_BUSY: begin
        stall_int = 1'b1;
        cnt_d     = cnt_q - CNTW'(1);
        if (op_q == CMD_MUL) begin
          if (b_q[0]) acc_d = acc_q + a_q;
          a_d = a_q << 1;
          b_d = b_q >> 1;
        end else if (!div_diff[WORD_LEN]) begin
          acc_d = div_diff[WORD_LEN-1:0];
          a_d   = {a_q[WORD_LEN-2:0], 1'b1};
        end else begin
          acc_d = div_r[WORD_LEN-1:0];
          a_d   = {a_q[WORD_LEN-2:0], 1'b0};
        end
        if (cnt_q == CNTW'(1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    mdu_res = (op_q == CMD_DIVU) ? a_q : acc_q;
    kill    = rst | stall_int;

    bus.stall        = stall_int & ~rst;
    bus.alu_result   = kill ? '0 : ((state_q == S_DONE) ? mdu_res : alu_comb);
    bus.MEM_R_EN_out = bus.MEM_R_EN & ~kill;
    bus.MEM_W_EN_out = bus.MEM_W_EN & ~kill;
    bus.WB_EN_out    = bus.WB_EN    & ~kill;
    bus.br_taken_out = bus.brTaken  & ~kill;
    bus.st_value_out = op_s;
    bus.br_addr      = bus.PC + op_b;
    bus.dest_out     = bus.dest;
  end
endmodule
